// File: rtl/scan_index_gen_pkg.sv
// Shared definitions for the scan sequencer and the downstream 3-to-8 decoder stage.
package scan_index_gen_pkg;

    localparam int unsigned SEL_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHOW  = 2'd1,
        S_BLANK = 2'd2
    } scan_state_t;

endpackage

// File: rtl/scan_index_gen_tick_gen.sv
// Slot-width divider: counts while enabled, wraps at DIV-1 and flags the terminal count.
module tick_gen
    import scan_index_gen_pkg::*;
#(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CW = $clog2((DIV < 2) ? 2 : DIV);

    logic [CW-1:0] div_cnt;

    assign tc = (div_cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (clr) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= tc ? '0 : div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/scan_index_gen.sv
// Time-multiplexed scan sequencer: steps a slot index with a blanking gap between slots.
module scan_index_gen
    import scan_index_gen_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 4,
    parameter int unsigned NUM_SLOTS    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clr,
    output logic [SEL_W-1:0] sel,
    output logic             sel_en,
    output logic             slot_done,
    output logic             frame_done,
    output logic             busy
);

    localparam int unsigned BW       = $clog2((BLANK_CYCLES < 2) ? 2 : BLANK_CYCLES);
    localparam int unsigned BLK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SLOTS - 1);

    scan_state_t   state;
    logic [BW-1:0] blk_cnt;
    logic          tick;
    logic          wrap;

    // Divider only runs in SHOW; any other state holds it at zero so each
    // entry into SHOW gets a full CLK_DIV.
    tick_gen #(
        .DIV(CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr || (state != S_SHOW)),
        .en   (run && (state == S_SHOW)),
        .tc   (tick)
    );

    assign wrap = (sel == SEL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            sel        <= '0;
            sel_en     <= 1'b0;
            slot_done  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            blk_cnt    <= '0;
        end else begin
            slot_done  <= 1'b0;
            frame_done <= 1'b0;
            if (clr) begin
                sel     <= '0;
                blk_cnt <= '0;
                state   <= run ? S_SHOW : S_IDLE;
                sel_en  <= run;
                busy    <= run;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (run) begin
                            state  <= S_SHOW;
                            sel_en <= 1'b1;
                            busy   <= 1'b1;
                        end
                    end
                    S_SHOW: begin
                        if (!run) begin
                            state  <= S_IDLE;
                            sel_en <= 1'b0;
                            busy   <= 1'b0;
                        end else if (tick) begin
                            if (BLANK_CYCLES == 0) begin
                                sel        <= wrap ? '0 : sel + 1'b1;
                                slot_done  <= 1'b1;
                                frame_done <= wrap;
                            end else begin
                                state   <= S_BLANK;
                                blk_cnt <= '0;
                                sel_en  <= 1'b0;
                            end
                        end
                    end
                    S_BLANK: begin
                        if (!run) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else if (blk_cnt == BW'(BLK_LAST)) begin
                            sel        <= wrap ? '0 : sel + 1'b1;
                            slot_done  <= 1'b1;
                            frame_done <= wrap;
                            state      <= S_SHOW;
                            sel_en     <= 1'b1;
                        end else begin
                            blk_cnt <= blk_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state  <= S_IDLE;
                        sel_en <= 1'b0;
                        busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
